// File: rtl/display_scan_if.sv
// Value-load handshake between the numeric datapath and the display scan controller.
// The datapath drives the master side; the controller drives val_ready.
interface display_scan_if #(
  parameter int unsigned DIGITS = 4
) ();
  logic [4*DIGITS-1:0] val_data;
  logic [DIGITS-1:0]   val_dp;
  logic                val_valid;
  logic                val_ready;

  modport master (
    output val_data,
    output val_dp,
    output val_valid,
    input  val_ready
  );

  modport slave (
    input  val_data,
    input  val_dp,
    input  val_valid,
    output val_ready
  );
endinterface

// File: rtl/display_scan_controller.sv
// Time-multiplexed 7-segment scan controller with a one-entry pending buffer, a shared hex
// decoder, a blanking gap before each digit and optional leading-zero blanking.
module display_scan_controller #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 50,
  parameter bit          LZB          = 1'b1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  display_scan_if.slave     val_if,
  output logic [6:0]        seg_o,
  output logic              dp_o,
  output logic [DIGITS-1:0] digit_en_o,
  output logic              frame_done_o
);

  typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

  localparam int unsigned TMax = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned TW   = $clog2(TMax + 1);
  localparam int unsigned IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [TW-1:0] DwellLast = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] BlankLast = TW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] LastIdx   = IW'(DIGITS - 1);
  // With no blanking gap every digit change goes straight to the next lit digit.
  localparam state_e        LeadSt    = (BLANK_CYCLES == 0) ? StShow : StBlank;

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [DIGITS-1:0]   dpr_q, dpr_d;
  logic [4*DIGITS-1:0] pend_data_q, pend_data_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_full_q, pend_full_d;

  logic                frame_end;
  logic [DIGITS-1:0]   upper_zero;
  logic [3:0]          cur_nib;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'h3F;
      4'h1:    hex7 = 7'h06;
      4'h2:    hex7 = 7'h5B;
      4'h3:    hex7 = 7'h4F;
      4'h4:    hex7 = 7'h66;
      4'h5:    hex7 = 7'h6D;
      4'h6:    hex7 = 7'h7D;
      4'h7:    hex7 = 7'h07;
      4'h8:    hex7 = 7'h7F;
      4'h9:    hex7 = 7'h6F;
      4'hA:    hex7 = 7'h77;
      4'hB:    hex7 = 7'h7C;
      4'hC:    hex7 = 7'h39;
      4'hD:    hex7 = 7'h5E;
      4'hE:    hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      timer_q     <= '0;
      disp_q      <= '0;
      dpr_q       <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      disp_q      <= disp_d;
      dpr_q       <= dpr_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      pend_full_q <= pend_full_d;
    end
  end

  assign frame_end        = (state_q == StShow) && (timer_q == DwellLast) && (idx_q == LastIdx);
  assign val_if.val_ready = ~pend_full_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    disp_d      = disp_q;
    dpr_d       = dpr_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_full_d = pend_full_q;

    // Capture needs an empty buffer and commit a full one, so the two never collide.
    if (val_if.val_valid && !pend_full_q) begin
      pend_data_d = val_if.val_data;
      pend_dp_d   = val_if.val_dp;
      pend_full_d = 1'b1;
    end
    if (pend_full_q && ((state_q == StIdle) || frame_end)) begin
      disp_d      = pend_data_q;
      dpr_d       = pend_dp_q;
      pend_full_d = 1'b0;
    end

    if (!enable_i) begin
      state_d = StIdle;
      idx_d   = '0;
      timer_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = LeadSt;
          idx_d   = '0;
          timer_d = '0;
        end
        StBlank: begin
          if (timer_q == BlankLast) begin
            state_d = StShow;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        StShow: begin
          if (timer_q == DwellLast) begin
            state_d = LeadSt;
            timer_d = '0;
            idx_d   = (idx_q == LastIdx) ? '0 : idx_q + IW'(1);
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          idx_d   = '0;
          timer_d = '0;
        end
      endcase
    end
  end

  // upper_zero[i]: nibbles i..DIGITS-1 of the shown value are all zero.
  always_comb begin
    logic acc;
    upper_zero = '0;
    acc        = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc           = acc & (disp_q[4*i +: 4] == 4'h0);
      upper_zero[i] = acc;
    end
  end

  assign cur_nib = disp_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    seg_o        = '0;
    dp_o         = 1'b0;
    digit_en_o   = '0;
    frame_done_o = frame_end;
    if (state_q == StShow) begin
      digit_en_o[idx_q] = 1'b1;
      dp_o              = dpr_q[idx_q];
      seg_o             = (LZB && (idx_q != '0) && upper_zero[idx_q]) ? 7'h00 : hex7(cur_nib);
    end
  end

endmodule
